instruction_fetch_unit: RTL and testbench

//   PC register and fetch sequencer in front of decode and immediate generation. Issues one instruction-memory

---
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC register and single-outstanding instruction fetch sequencer
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic [1:0]  redir_kind,
  input  logic [31:0] redir_imm,
  input  logic [31:0] redir_rs1,
  input  logic        halt_req,
  output logic        halted,
  output logic [1:0]  fault
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [31:0] pc;
  logic [7:0]  wait_cnt;
  logic [31:0] target;

  // The fetch address is always the PC register; it is only meaningful while imem_req is high.
  assign imem_addr = pc;

  // Next-PC selection from the feedback presented in the accept cycle; adds wrap silently.
  always_comb begin
    target = pc + 32'd4;
    case (redir_kind)
      2'd1:    target = inst_pc + redir_imm;
      2'd2:    target = (redir_rs1 + redir_imm) & 32'hFFFF_FFFE;
      default: target = pc + 32'd4;
    endcase
  end

  // Fetch sequencer: REQ issues a single strobe, WAIT collects the word or times out,
  // HOLD presents it to decode until accepted, HALT parks until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      wait_cnt   <= 8'd0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      inst_out   <= 32'd0;
      inst_pc    <= 32'd0;
      halted     <= 1'b0;
      fault      <= 2'd0;
    end else begin
      case (state)
        S_REQ: begin
          // Coming out of reset the strobe is raised one cycle late so outputs stay quiet in reset.
          wait_cnt <= 8'd0;
          if (imem_req) begin
            imem_req <= 1'b0;
            state    <= S_WAIT;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_WAIT: begin
          // A response on the final permitted cycle still wins over the timeout.
          if (imem_rvalid) begin
            inst_out   <= imem_rdata;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end else if (wait_cnt == LAST_WAIT) begin
            fault  <= 2'd2;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            if (target[1:0] != 2'b00) begin
              // Misaligned target: keep the PC of the offending fetch and stop.
              fault  <= 2'd1;
              halted <= 1'b1;
              state  <= S_HALT;
            end else if (halt_req) begin
              pc     <= target;
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              pc       <= target;
              imem_req <= 1'b1;
              state    <= S_REQ;
            end
          end
        end
        S_HALT: begin
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
          halted     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam int          MAX_WAIT = 15;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [1:0]  redir_kind;
  logic [31:0] redir_imm;
  logic [31:0] redir_rs1;
  logic        halt_req;
  logic        halted;
  logic [1:0]  fault;

  instruction_fetch_unit #(
    .RESET_PC(RESET_PC),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_out(inst_out),
    .inst_pc(inst_pc),
    .redir_kind(redir_kind),
    .redir_imm(redir_imm),
    .redir_rs1(redir_rs1),
    .halt_req(halt_req),
    .halted(halted),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  logic [31:0] exp_pc;
  bit          stopped;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    imem_rvalid = 1'b0;
    inst_ready  = 1'b0;
    halt_req    = 1'b0;
    redir_kind  = 2'd0;
    tick();
    tick();
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_imem_req", imem_req, 0);
    check_eq("rst_imem_addr", imem_addr, RESET_PC);
    reset  = 1'b0;
    exp_pc = RESET_PC;
  endtask

  task automatic check_parked(input logic [1:0] exp_fault);
    for (int i = 0; i < 4; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      tick();
      check_eq("halt_no_req", imem_req, 0);
      check_eq("halt_halted", halted, 1);
      check_eq("halt_inst_valid", inst_valid, 0);
      check_eq("halt_fault", fault, exp_fault);
    end
    imem_rvalid = 1'b0;
  endtask

  // One full fetch transaction: lat is the WAIT cycle carrying rvalid (above MAX_WAIT means never),
  // stall is the number of cycles decode holds off, then the accept carries the redirect.
  task automatic fetch(input int lat, input int stall, input logic [1:0] kind,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic hlt,
                       input logic stale);
    logic [31:0] data;
    logic [31:0] tgt;
    int          n;
    stopped = 1'b0;
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    imem_rvalid = 1'b0;
    check_eq("req_seen", imem_req, 1);
    check_eq("req_addr", imem_addr, exp_pc);
    imem_rvalid = stale;
    imem_rdata  = $urandom;
    tick();
    imem_rvalid = 1'b0;
    check_eq("single_strobe", imem_req, 0);
    check_eq("no_early_valid", inst_valid, 0);
    if (lat > MAX_WAIT) begin
      repeat (MAX_WAIT - 1) tick();
      check_eq("timeout_not_early", halted, 0);
      tick();
      check_eq("timeout_fault", fault, 2);
      check_eq("timeout_halted", halted, 1);
      stopped = 1'b1;
      return;
    end
    repeat (lat - 1) tick();
    data        = $urandom;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
    check_eq("inst_valid", inst_valid, 1);
    check_eq("inst_out", inst_out, data);
    check_eq("inst_pc", inst_pc, exp_pc);
    check_eq("no_fault", fault, 0);
    for (int i = 0; i < stall; i++) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      redir_kind  = 2'($urandom_range(0, 3));
      redir_imm   = $urandom;
      halt_req    = 1'($urandom_range(0, 1));
      tick();
      check_eq("stall_valid", inst_valid, 1);
      check_eq("stall_inst_out", inst_out, data);
      check_eq("stall_inst_pc", inst_pc, exp_pc);
      check_eq("stall_no_req", imem_req, 0);
    end
    imem_rvalid = 1'b0;
    inst_ready  = 1'b1;
    redir_kind  = kind;
    redir_imm   = imm;
    redir_rs1   = rs1;
    halt_req    = hlt;
    tick();
    inst_ready = 1'b0;
    redir_kind = 2'($urandom_range(0, 3));
    redir_imm  = $urandom;
    redir_rs1  = $urandom;
    halt_req   = 1'($urandom_range(0, 1));
    check_eq("accept_drops_valid", inst_valid, 0);
    case (kind)
      2'd1:    tgt = exp_pc + imm;
      2'd2:    tgt = (rs1 + imm) & ~32'd1;
      default: tgt = exp_pc + 32'd4;
    endcase
    if (tgt % 4 != 0) begin
      check_eq("misalign_fault", fault, 1);
      check_eq("misalign_halted", halted, 1);
      check_eq("misalign_pc_kept", imem_addr, exp_pc);
      stopped = 1'b1;
    end else if (hlt) begin
      check_eq("ecall_halted", halted, 1);
      check_eq("ecall_fault", fault, 0);
      check_eq("ecall_pc", imem_addr, tgt);
      stopped = 1'b1;
    end else begin
      check_eq("redirect_req", imem_req, 1);
      exp_pc = tgt;
    end
  endtask

  initial begin
    logic [1:0]  kind;
    logic [31:0] imm;
    logic [31:0] rs1;
    int          lat;
    bit          bad;
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    inst_ready  = 1'b0;
    redir_kind  = 2'd0;
    redir_imm   = 32'd0;
    redir_rs1   = 32'd0;
    halt_req    = 1'b0;
    do_reset();

    // Sequential fetches, then a 5-cycle decode stall, then the redirect examples.
    fetch(1, 0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    fetch(1, 0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    fetch(1, 0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    fetch(1, 5, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check_eq("pc_at_0x10", exp_pc, 32'h10);
    fetch(1, 0, 2'd1, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b0);
    fetch(1, 0, 2'd2, 32'd4, 32'h101, 1'b0, 1'b0);
    check_eq("jalr_target", exp_pc, 32'h104);
    fetch(1, 0, 2'd2, 32'd0, 32'h20, 1'b0, 1'b0);
    fetch(1, 0, 2'd1, 32'd6, 32'd0, 1'b0, 1'b0);
    check_parked(2'd1);
    do_reset();

    // Wrap-around past the top of the address space, then a halting ECALL.
    fetch(2, 0, 2'd2, 32'd0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    fetch(2, 1, 2'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    check_eq("wrap_to_zero", exp_pc, 32'd0);
    fetch(1, 0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    check_parked(2'd0);
    do_reset();

    // Memory never answers, then answers on the last allowed cycle.
    fetch(MAX_WAIT + 1, 0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check_parked(2'd2);
    do_reset();
    fetch(MAX_WAIT, 0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reset while waiting, with a late response arriving during the restarted REQ.
    fetch(1, 0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    reset       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    reset  = 1'b0;
    exp_pc = RESET_PC;
    check_eq("reset_in_wait_valid", inst_valid, 0);
    check_eq("reset_in_wait_addr", imem_addr, RESET_PC);
    fetch(2, 0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Randomized fetch stream against the reference next-PC rules.
    for (int t = 0; t < 300; t++) begin
      lat  = ($urandom_range(0, 39) == 0) ? MAX_WAIT + 1 : int'($urandom_range(1, MAX_WAIT));
      kind = 2'($urandom_range(0, 3));
      rs1  = $urandom;
      bad  = ($urandom_range(0, 15) == 0);
      imm  = $urandom;
      if (kind == 2'd1) begin
        imm = imm & 32'hFFFF_FFFC;
        if (bad) imm = imm | 32'($urandom_range(1, 3));
      end else if (kind == 2'd2) begin
        if (((rs1 + imm) & 32'd2) != 0) imm = imm + 32'd2;
        if (bad) imm = imm ^ 32'd2;
      end
      fetch(lat, int'($urandom_range(0, 3)), kind, imm, rs1,
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
      if (stopped) begin
        check_parked(fault);
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
